// File: rtl/pkt_bank_buffer_if.sv
// Bus bundle for pkt_bank_buffer: write port, read handshake and status.
// The master side drives writes and read requests; the slave is the buffer.
interface pkt_bank_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 2
);
    localparam int BW = $clog2(NUM_BANKS + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  wr_abort;
    logic                  rd_start;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  rd_busy;
    logic                  rd_done;
    logic                  empty;
    logic                  full;
    logic [BW-1:0]         banks_used;
    logic [15:0]           drop_cnt;

    modport master (
        output wr_en, din, wr_abort, rd_start, rd_en,
        input  dout, valid, rd_busy, rd_done, empty, full, banks_used, drop_cnt
    );

    modport slave (
        input  wr_en, din, wr_abort, rd_start, rd_en,
        output dout, valid, rd_busy, rd_done, empty, full, banks_used, drop_cnt
    );
endinterface

// File: rtl/pkt_bank_buffer.sv
// Multi-bank packet buffer: whole packets are written into circular banks and
// read back oldest-first, one bank released per completed readout.
module pkt_bank_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_SIZE   = 4864,
    parameter int NUM_BANKS  = 2
) (
    input  logic             sys_clk,
    input  logic             rst,
    pkt_bank_buffer_if.slave bus
);
    localparam int AW    = $clog2(PKT_SIZE);
    localparam int BW    = $clog2(NUM_BANKS + 1);
    localparam int KW    = $clog2(NUM_BANKS);
    localparam int DEPTH = NUM_BANKS * PKT_SIZE;
    localparam int MW    = $clog2(DEPTH);

    localparam logic [AW-1:0] LAST_ADDR = AW'(PKT_SIZE - 1);
    localparam logic [KW-1:0] LAST_BANK = KW'(NUM_BANKS - 1);
    localparam logic [BW-1:0] FULL_CNT  = BW'(NUM_BANKS);
    localparam logic [MW-1:0] BANK_SPAN = MW'(PKT_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } rd_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [KW-1:0]  wr_bank_q, wr_bank_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;
    logic [KW-1:0]  rd_bank_q, rd_bank_d;
    logic [BW-1:0]  used_q, used_d;
    logic [15:0]    drop_q, drop_d;
    rd_state_t      state_q, state_d;
    logic           valid_q, valid_d;
    logic [DATA_WIDTH-1:0] dout_q;

    logic           full;
    logic           empty;
    logic           wr_req;
    logic           wr_fire;
    logic           commit;
    logic           drop;
    logic           rd_fire;
    logic           release_bank;
    logic [MW-1:0]  wr_ptr;
    logic [MW-1:0]  rd_ptr;

    function automatic logic [KW-1:0] next_bank(input logic [KW-1:0] b);
        return (b == LAST_BANK) ? '0 : b + KW'(1);
    endfunction

    assign full  = (used_q == FULL_CNT);
    assign empty = (used_q == '0);

    // The bank under readout stays counted in used_q until DONE, so a write
    // can only land on it once it has been released.
    assign wr_req       = bus.wr_en & ~bus.wr_abort;
    assign wr_fire      = wr_req & ~full;
    assign commit       = wr_fire & (wr_addr_q == LAST_ADDR);
    assign drop         = wr_req & full;
    assign rd_fire      = (state_q == READ) & bus.rd_en;
    assign release_bank = (state_q == DONE);

    assign wr_ptr = MW'(wr_bank_q) * BANK_SPAN + MW'(wr_addr_q);
    assign rd_ptr = MW'(rd_bank_q) * BANK_SPAN + MW'(rd_addr_q);

    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_bank_d = wr_bank_q;
        drop_d    = drop_q;
        if (bus.wr_abort) begin
            wr_addr_d = '0;
        end else if (wr_fire) begin
            if (commit) begin
                wr_addr_d = '0;
                wr_bank_d = next_bank(wr_bank_q);
            end else begin
                wr_addr_d = wr_addr_q + AW'(1);
            end
        end
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_comb begin
        used_d = used_q;
        case ({commit, release_bank})
            2'b10:   used_d = used_q + BW'(1);
            2'b01:   used_d = used_q - BW'(1);
            default: used_d = used_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        valid_d   = rd_fire;
        case (state_q)
            IDLE: begin
                if (bus.rd_start && !empty) begin
                    state_d   = READ;
                    rd_addr_d = '0;
                end
            end
            READ: begin
                if (bus.rd_en) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                rd_addr_d = '0;
                rd_bank_d = next_bank(rd_bank_q);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_addr_q <= '0;
            wr_bank_q <= '0;
            rd_addr_q <= '0;
            rd_bank_q <= '0;
            used_q    <= '0;
            drop_q    <= '0;
            state_q   <= IDLE;
            valid_q   <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_bank_q <= wr_bank_d;
            rd_addr_q <= rd_addr_d;
            rd_bank_q <= rd_bank_d;
            used_q    <= used_d;
            drop_q    <= drop_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Registered read port; holds the last word whenever no read fires.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_fire) begin
            dout_q <= mem[rd_ptr];
        end
    end

    assign bus.dout       = dout_q;
    assign bus.valid      = valid_q;
    assign bus.rd_busy    = (state_q != IDLE);
    assign bus.rd_done    = (state_q == DONE);
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.banks_used = used_q;
    assign bus.drop_cnt   = drop_q;
endmodule
